// File: rtl/lmsm_sequencer.sv
// LM/SM micro-sequencer: expands one multi-register instruction into one transfer per cycle, lowest register first.
// Optional base-register writeback of the final address is enabled by defining LMSM_BASE_WB_EN.
module lmsm_sequencer #(
    parameter int AW     = 16,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              is_lm,
    input  logic [MASK_W-1:0] imm_mask,
    input  logic [AW-1:0]     base_addr,
    input  logic [2:0]        base_reg,
    input  logic              hold,
    output logic              xfer_valid,
    output logic [2:0]        xfer_reg,
    output logic [AW-1:0]     xfer_addr,
    output logic              xfer_lm,
    output logic              rf_write_en,
    output logic              mem_write_en,
    output logic              pc_hold,
    output logic              busy,
    output logic              done
`ifdef LMSM_BASE_WB_EN
    ,
    output logic              wb_valid,
    output logic [2:0]        wb_reg,
    output logic [AW-1:0]     wb_data
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    // R7 is the PC and must never be a transfer target.
    localparam logic [MASK_W-1:0] R7_BIT = MASK_W'(1) << 7;

    state_t            state;
    logic [MASK_W-1:0] rem_mask;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     base;
    logic              op;
    logic [2:0]        breg;

    logic              accept;
    logic              step;
    logic              last;
    logic [2:0]        low_idx;
    logic [MASK_W-1:0] mask_next;

    assign accept    = start_valid & start_ready;
    assign step      = (state == RUN) & ~hold;
    assign mask_next = rem_mask & (rem_mask - MASK_W'(1));
    // True both for the final set bit and for an empty mask.
    assign last      = (mask_next == '0);

    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (rem_mask[i]) low_idx = 3'(i);
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign xfer_valid   = step & (rem_mask != '0);
    assign xfer_reg     = xfer_valid ? low_idx : 3'd0;
    assign xfer_addr    = xfer_valid ? (base + cnt) : '0;
    assign xfer_lm      = op;
    assign rf_write_en  = xfer_valid & op;
    assign mem_write_en = xfer_valid & ~op;
    assign done         = step & last;
    assign pc_hold      = accept | (busy & ~done);

`ifdef LMSM_BASE_WB_EN
    assign wb_valid = done & (breg != 3'd7);
    assign wb_reg   = wb_valid ? breg : 3'd0;
    assign wb_data  = wb_valid ? (base + cnt + AW'(rem_mask != '0)) : '0;
`else
    logic unused_breg;
    assign unused_breg = ^breg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem_mask <= '0;
            cnt      <= '0;
            base     <= '0;
            op       <= 1'b0;
            breg     <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_mask <= imm_mask & ~R7_BIT;
                        base     <= base_addr;
                        op       <= is_lm;
                        breg     <= base_reg;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (rem_mask != '0) begin
                            rem_mask <= mask_next;
                            cnt      <= cnt + AW'(1);
                        end
                        if (last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Decode-stage micro-sequencer for the IITB-RISC multi-register instructions: LM (load multiple) and SM (store multiple).
- Takes one decoded LM/SM instruction and expands it into one register transfer per cycle.
- Drives register-file read/write addresses and memory addresses.
- Holds the PC (R7) update in the register file while the expansion runs.
- Sits directly upstream of the register file and its PC-next-value selection.

Parameters:
- AW, 16, address/data width
- MASK_W, 8, immediate mask width; bit i maps to register Ri

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_valid  in  1  decoded LM/SM instruction present
- start_ready  out  1  sequencer can accept; high only in IDLE
- is_lm  in  1  1 = LM, 0 = SM; sampled on accept
- imm_mask  in  MASK_W  register mask; sampled on accept
- base_addr  in  AW  start memory address (RA contents); sampled on accept
- base_reg  in  3  RA index; sampled on accept
- hold  in  1  downstream stall; freezes sequencing
- xfer_valid  out  1  a transfer is issued this cycle
- xfer_reg  out  3  register index of the current transfer
- xfer_addr  out  AW  memory address of the current transfer
- xfer_lm  out  1  latched op type (1 = load)
- rf_write_en  out  1  xfer_valid & xfer_lm
- mem_write_en  out  1  xfer_valid & ~xfer_lm
- pc_hold  out  1  deasserts the PC enable upstream of the register file
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on instruction completion

Behaviour:
- Reset values: state IDLE; all outputs 0 except start_ready = 1; internal mask/count/base = 0.
- Reset asserted mid-operation: immediate return to IDLE; no further transfers; done is not pulsed.
- States: IDLE, RUN.
- IDLE:
  - Accept happens when start_valid & start_ready.
  - On accept: latch rem_mask = imm_mask with bit 7 forced to 0 (R7 is never a transfer target); latch base, op, and base_reg; clear cnt; go to RUN.
- RUN, hold = 1:
  - No transfer; xfer_valid = 0; all state frozen.
- RUN, hold = 0, rem_mask != 0:
  - xfer_valid = 1.
  - xfer_reg = index of the lowest set bit of rem_mask (ascending register order).
  - xfer_addr = base + cnt, modulo 2^AW; wraps from 0xFFFF to 0x0000 with no error.
  - Then clear that bit and increment cnt.
  - If that bit was the last set bit: done = 1 in the same cycle and go to IDLE.
- RUN, hold = 0, rem_mask == 0 (empty mask): xfer_valid = 0, done = 1, go to IDLE.
- Latency: accept cycle + N transfer cycles (N = popcount of mask[6:0], minimum 1 cycle) when hold stays low.
- Outputs xfer_*, rf_write_en, mem_write_en, and done are combinational from registered state and hold. They are stable while hold = 0.
- pc_hold = (start_valid & start_ready) | (busy & ~done). So the PC is frozen from the accept cycle through the cycle before completion, and is released in the done cycle.
- start_valid while busy is ignored; upstream must keep it asserted until accepted.
- Back-to-back: a new accept may occur the cycle after done (state is IDLE again).

Optional Feature:
- Macro LMSM_BASE_WB_EN.
- Defined:
  - Adds outputs wb_valid (1 bit), wb_reg (3 bits), and wb_data (AW bits).
  - In the done cycle, wb_valid = 1, wb_reg = latched base_reg, wb_data = base + N (final address, modulo 2^AW).
  - wb_valid is suppressed if base_reg == 7.
  - wb_valid is 0 in all other cycles and at reset.
- Undefined: the ports are absent; the base register is never modified.

Test Plan:
- LM, mask 0x0B, base 0x0100, hold 0 -> 3 cycles of xfer_valid with (reg, addr) = (0, 0x0100), (1, 0x0101), (3, 0x0102); rf_write_en high on each; done on the 3rd; pc_hold high from the accept cycle through the 2nd transfer cycle.
- SM, mask 0x00 -> one RUN cycle with xfer_valid = 0 and done = 1; no mem_write_en; start_ready back to 1 the next cycle.
- SM, mask 0xFF, base 0xFFFE -> 7 transfers, R0..R6, addresses 0xFFFE, 0xFFFF, 0x0000 .. 0x0004; R7 is never issued.
- LM, mask 0x05, hold high for 2 cycles after the first transfer -> xfer_valid = 0 for those 2 cycles; second transfer is (2, base+1) after hold drops; done is delayed accordingly.
- rst pulsed during the 2nd transfer of mask 0x0F -> outputs 0 and start_ready = 1 asynchronously; no done; a new instruction is accepted normally after rst is released.
- With LMSM_BASE_WB_EN defined: LM, mask 0x06, base_reg 5, base 0x0010 -> done cycle shows wb_valid = 1, wb_reg = 5, wb_data = 0x0012; repeating with base_reg 7 gives wb_valid = 0.
